// File: rtl/rr_mul_pkg.sv
// rtl/rr_mul_pkg.sv - shared types and constants for the recursive 4x4 sequential multiplier
package rr_mul_pkg;

   localparam int W  = 4;
   localparam int WH = 3;
   localparam int WL = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Left shift applied to each sub-product: AL*BL, AH*BL, AL*BH, AH*BH.
   localparam logic [1:0] STEP_SHIFT [4] = '{2'd0, 2'd1, 2'd1, 2'd2};

endpackage

// File: rtl/exact_nr_3x3.sv
// rtl/exact_nr_3x3.sv - combinational exact 3x3 unsigned multiplier
module exact_nr_3x3 (
   input  logic [2:0] a,
   input  logic [2:0] b,
   output logic [5:0] p
);

   logic [5:0] pp0;
   logic [5:0] pp1;
   logic [5:0] pp2;

   always_comb begin
      pp0 = {3'b000, a}       & {6{b[0]}};
      pp1 = {2'b00, a, 1'b0}  & {6{b[1]}};
      pp2 = {1'b0, a, 2'b00}  & {6{b[2]}};
      p   = pp0 + pp1 + pp2;
   end

endmodule

// File: rtl/rr4x4_seq_mul.sv
// rtl/rr4x4_seq_mul.sv - 4x4 multiplier built from four time-multiplexed 3x3 sub-products
module rr4x4_seq_mul
   import rr_mul_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_p,
   output logic         busy,
   output logic [7:0]   op_count
);

   state_t          state_q, state_d;
   logic [1:0]      step_q, step_d;
   logic [7:0]      acc_q, acc_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [7:0]      cnt_q, cnt_d;

   logic [WH-1:0]   a_hi, a_lo, b_hi, b_lo;
   logic [WH-1:0]   sub_a, sub_b;
   logic [2*WH-1:0] sub_p;
   logic [7:0]      addend;

   // Low halves are single bits, zero-extended to the sub-multiplier width.
   assign a_hi = a_q[W-1:WL];
   assign b_hi = b_q[W-1:WL];
   assign a_lo = {{(WH-WL){1'b0}}, a_q[WL-1:0]};
   assign b_lo = {{(WH-WL){1'b0}}, b_q[WL-1:0]};

   always_comb begin
      sub_a = a_lo;
      sub_b = b_lo;
      unique case (step_q)
         2'd0: begin sub_a = a_lo; sub_b = b_lo; end
         2'd1: begin sub_a = a_hi; sub_b = b_lo; end
         2'd2: begin sub_a = a_lo; sub_b = b_hi; end
         2'd3: begin sub_a = a_hi; sub_b = b_hi; end
         default: ;
      endcase
   end

   exact_nr_3x3 u_sub_mul (
      .a (sub_a),
      .b (sub_b),
      .p (sub_p)
   );

   assign addend = {2'b00, sub_p} << STEP_SHIFT[step_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= 2'd0;
         acc_q   <= 8'd0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               acc_d   = 8'd0;
               step_d  = 2'd0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d  = acc_q + addend;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               cnt_d   = cnt_q + 8'd1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == CALC) || (state_q == DONE);
      out_p     = acc_q;
      op_count  = cnt_q;
   end

endmodule

// File: tb/tb_rr4x4_seq_mul.sv
// tb/tb_rr4x4_seq_mul.sv - self-checking bench for rr4x4_seq_mul
module tb_rr4x4_seq_mul;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_p;
   logic       busy;
   logic [7:0] op_count;

   int         total;
   int         passed;
   int         cyc;
   logic [7:0] op_model;

   rr4x4_seq_mul dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
      int unsigned prod;
      prod = int'(a) * int'(b);
      return prod[7:0];
   endfunction

   // One full operation; operands and in_valid are scrambled while the DUT computes.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int hold);
      int         lat;
      int         guard;
      logic [7:0] exp_p;
      exp_p = ref_mul(a, b);
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_before_op", {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 20) begin
         in_valid = 1'($urandom);
         in_a     = 4'($urandom);
         in_b     = 4'($urandom);
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      check("latency", lat, 4);
      check("product", {24'd0, out_p}, {24'd0, exp_p});
      check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
      check("busy_in_done", {31'd0, busy}, 32'd1);
      for (int k = 0; k < hold; k++) begin
         in_a = 4'($urandom);
         in_b = 4'($urandom);
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_product", {24'd0, out_p}, {24'd0, exp_p});
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      op_model = op_model + 8'd1;
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_after_hs", {31'd0, out_valid}, 32'd0);
      check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
      check("busy_after_hs", {31'd0, busy}, 32'd0);
      check("op_count", {24'd0, op_count}, {24'd0, op_model});
   endtask

   initial begin
      int         guard;
      int         last_acc;
      int         lat;
      logic       saw_valid;
      logic [3:0] ra;
      logic [3:0] rb;

      total     = 0;
      passed    = 0;
      op_model  = 8'd0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 4'd0;
      in_b      = 4'd0;
      out_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_p", {24'd0, out_p}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_op_count", {24'd0, op_count}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      run_op(4'd3, 4'd5, 0);
      run_op(4'd15, 4'd15, 0);
      run_op(4'd0, 4'd9, 0);
      run_op(4'd1, 4'd1, 0);
      run_op(4'd6, 4'd7, 10);
      for (int i = 0; i < 6; i++) begin
         run_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
      end

      // Reset during step 2 of 9*9.
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 4'd9;
      in_b     = 4'd9;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      op_model = 8'd0;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_out_p", {24'd0, out_p}, 32'd0);
      check("midrst_op_count", {24'd0, op_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      saw_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      check("midrst_no_valid", {31'd0, saw_valid}, 32'd0);
      check("midrst_op_count_hold", {24'd0, op_count}, 32'd0);
      run_op(4'd2, 4'd3, 0);

      // Back-to-back: 256-pair sweep plus one extra op, starting from a clean count.
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      op_model  = 8'd0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      last_acc  = 0;
      for (int i = 0; i < 257; i++) begin
         ra = 4'(i >> 4);
         rb = 4'(i);
         if (i == 256) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
         end
         in_a = ra;
         in_b = rb;
         guard = 0;
         while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 20) check("b2b_accept_timeout", guard, 0);
         if (i > 0 && i < 8) check("b2b_interval", cyc - last_acc, 6);
         last_acc = cyc;
         in_a = ra;
         in_b = rb;
         @(posedge clk);
         @(negedge clk);
         lat = 0;
         while (!out_valid && lat < 20) begin
            in_a = 4'($urandom);
            in_b = 4'($urandom);
            @(posedge clk);
            @(negedge clk);
            lat++;
         end
         check("sweep_product", {24'd0, out_p}, {24'd0, ref_mul(ra, rb)});
         op_model = op_model + 8'd1;
         if (i == 256) in_valid = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      @(negedge clk);
      check("wrap_op_count", {24'd0, op_count}, {24'd0, op_model});
      check("wrap_op_count_is_1", {24'd0, op_count}, 32'd1);
      check("wrap_idle", {31'd0, in_ready}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rr4x4_seq_mul.md
RR4X4_SEQ_MUL -- requirements
Module: rr4x4_seq_mul

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  operand pair present.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 in_a  input  4  unsigned multiplicand.
REQ-007 in_b  input  4  unsigned multiplier.
REQ-008 out_valid  output  1  product available.
REQ-009 out_ready  input  1  consumer accepts the product.
REQ-010 out_p  output  8  unsigned product in_a*in_b.
REQ-011 busy  output  1  high in CALC or DONE.
REQ-012 op_count  output  8  number of completed output handshakes, wraps modulo 256.

Function
REQ-013 The block SHALL compute the 4x4 product recursively from a 3-bit high / 1-bit low split of each operand: AH=a[3:1], AL=a[0], BH=b[3:1], BL=b[0].
REQ-014 The block SHALL contain one shared 3x3 exact sub-multiplier and time-multiplex all four sub-products through it; 1-bit operands are zero-extended to 3 bits.
REQ-015 The FSM states SHALL be IDLE, CALC, DONE, plus a 2-bit step counter used in CALC.
REQ-016 in_ready SHALL be 1 only in IDLE; an input handshake is in_valid&&in_ready at a rising edge.
REQ-017 On an input handshake the block SHALL register in_a and in_b, clear the 8-bit accumulator, set step=0 and enter CALC.
REQ-018 In CALC the step schedule SHALL be: step 0 adds AL*BL<<0; step 1 adds AH*BL<<1; step 2 adds AL*BH<<1; step 3 adds AH*BH<<2. Each add occurs at the clock edge ending that step.
REQ-019 Accumulation SHALL be 8 bits wide; no intermediate or final sum exceeds 225, so no overflow handling is required.
REQ-020 After the step-3 add the block SHALL enter DONE with out_valid=1. This gives a latency of 4 edges from the input handshake edge to out_valid high.
REQ-021 In DONE, out_p SHALL equal the accumulator, and out_p and out_valid SHALL hold stable until out_ready=1.
REQ-022 On the output handshake (out_valid&&out_ready) the block SHALL return to IDLE and increment op_count, wrapping 255->0.
REQ-023 in_valid and the operand inputs SHALL be ignored outside IDLE, including changes during CALC.
REQ-024 Minimum throughput SHALL be one product per 6 cycles: 1 accept, 4 CALC, 1 DONE with out_ready=1.
REQ-025 out_p SHALL be driven from the accumulator register in every state; its value is only meaningful while out_valid=1.

Reset
REQ-026 While rst=1 the block SHALL immediately force: state=IDLE, step=0, accumulator=0, registered operands=0, op_count=0.
REQ-027 Reset output values SHALL be: in_ready=1 (after rst deasserts), out_valid=0, out_p=0, busy=0, op_count=0.
REQ-028 A reset asserted mid-CALC or mid-DONE SHALL discard the operation without producing an output handshake or an op_count increment.

Structure
REQ-029 A shared package rr_mul_pkg SHALL hold the state enum (IDLE, CALC, DONE), the split constants (WH=3, WL=1, W=4), and the step-to-shift table.
REQ-030 The shared sub-multiplier SHALL be a single instance of the existing combinational exact_nr_3x3 sub-module; all sequencing, operand muxing and accumulation SHALL stay in rr4x4_seq_mul.

Verification
REQ-031 Reset, then a=3, b=5 with out_ready=1 -> out_valid high 4 edges after accept, out_p=15, op_count=1.
REQ-032 a=15, b=15 -> out_p=225; a=0, b=9 -> out_p=0; a=1, b=1 -> out_p=1; exhaustive 256-pair sweep against a reference model, zero mismatches.
REQ-033 a=6, b=7 with out_ready=0 for 10 cycles -> out_valid and out_p=42 stable throughout, in_ready=0; handshake on the first out_ready=1 cycle, then IDLE on the next cycle.
REQ-034 Assert rst during step 2 of a=9, b=9 -> out_valid never rises, op_count unchanged at 0, in_ready=1 after release; a new op a=2, b=3 yields 6.
REQ-035 Back-to-back ops with in_valid=1 and out_ready=1 continuously -> accepts every 6 cycles; after 257 ops op_count=1 (wrap).
REQ-036 Change in_a/in_b every cycle during CALC -> out_p reflects only the operands registered at the input handshake.
